// File: rtl/secret_flow_arb.sv
// secret_flow_arb: two-port packet round-robin arbiter feeding the shared secret_flow crypt datapath.
// Per-port EOP counters exist only when SECRET_FLOW_ARB_PKT_CNT_EN is defined; otherwise they read 0.

module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             nearly_full
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_LVL = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NF_LVL   = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   count;
    logic                      do_wr;
    logic                      do_rd;

    // Head word is visible combinationally so a write at edge N is readable right after edge N.
    assign empty       = (count == '0);
    assign nearly_full = (count >= NF_LVL);
    assign dout        = mem[rd_ptr];
    assign do_rd       = rd_en && !empty;
    assign do_wr       = wr_en && ((count != FULL_LVL) || do_rd);

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module secret_flow_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic [CTRL_WIDTH-1:0] in0_ctrl,
    input  logic                  in0_wr,
    output logic                  in0_rdy,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic [CTRL_WIDTH-1:0] in1_ctrl,
    input  logic                  in1_wr,
    output logic                  in1_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  grant,
    output logic                  pkt_active,
    output logic [31:0]           pkt_cnt0,
    output logic [31:0]           pkt_cnt1
);
    localparam int W = DATA_WIDTH + CTRL_WIDTH;

    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] HDR  = 3'b010;
    localparam logic [2:0] PKT  = 3'b100;

    logic [2:0]   state;
    logic         last_grant;
    logic [1:0]   empty;
    logic [1:0]   nearly_full;
    logic [1:0]   rd_en;
    logic [W-1:0] head0;
    logic [W-1:0] head1;
    logic         fifo_reset;
    logic         eop_done;

    assign fifo_reset = !reset;

    fallthrough_small_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(2)) u_fifo0 (
        .clk(clk), .reset(fifo_reset), .din({in0_data, in0_ctrl}), .wr_en(in0_wr),
        .rd_en(rd_en[0]), .dout(head0), .empty(empty[0]), .nearly_full(nearly_full[0])
    );

    fallthrough_small_fifo #(.WIDTH(W), .MAX_DEPTH_BITS(2)) u_fifo1 (
        .clk(clk), .reset(fifo_reset), .din({in1_data, in1_ctrl}), .wr_en(in1_wr),
        .rd_en(rd_en[1]), .dout(head1), .empty(empty[1]), .nearly_full(nearly_full[1])
    );

    assign in0_rdy = !nearly_full[0];
    assign in1_rdy = !nearly_full[1];

    assign {out_data, out_ctrl} = grant ? head1 : head0;
    assign pkt_active = (state != IDLE);
    assign out_wr     = pkt_active && !empty[grant] && out_rdy;
    assign rd_en[0]   = out_wr && !grant;
    assign rd_en[1]   = out_wr && grant;
    assign eop_done   = (state == PKT) && out_wr && (out_ctrl != '0);

    // Grant is decided only in IDLE, so a packet is never split between ports.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty[0] && !empty[1]) begin
                        grant <= !last_grant;
                        state <= HDR;
                    end else if (!empty[0]) begin
                        grant <= 1'b0;
                        state <= HDR;
                    end else if (!empty[1]) begin
                        grant <= 1'b1;
                        state <= HDR;
                    end
                end
                HDR: if (out_wr && (out_ctrl == '0)) state <= PKT;
                PKT: begin
                    if (eop_done) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SECRET_FLOW_ARB_PKT_CNT_EN
    logic [31:0] cnt0;
    logic [31:0] cnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (eop_done) begin
            if (grant) cnt1 <= cnt1 + 32'd1;
            else       cnt0 <= cnt0 + 32'd1;
        end
    end

    assign pkt_cnt0 = cnt0;
    assign pkt_cnt1 = cnt1;
`else
    assign pkt_cnt0 = '0;
    assign pkt_cnt1 = '0;
`endif
endmodule

// File: tb/tb_secret_flow_arb.sv
// Self-checking bench for secret_flow_arb: scenario table plus hand-written reset and back-pressure sequences.
// Expected words come from per-port scoreboard queues filled by the stimulus drivers.

module tb_secret_flow_arb;
    localparam int DW = 64;
    localparam int CW = 8;
`ifdef SECRET_FLOW_ARB_PKT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in0_data, in1_data;
    logic [CW-1:0] in0_ctrl, in1_ctrl;
    logic          in0_wr, in1_wr, in0_rdy, in1_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr, out_rdy, grant, pkt_active;
    logic [31:0]   pkt_cnt0, pkt_cnt1;

    always #5 clk = ~clk;

    secret_flow_arb #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .in0_data(in0_data), .in0_ctrl(in0_ctrl), .in0_wr(in0_wr), .in0_rdy(in0_rdy),
        .in1_data(in1_data), .in1_ctrl(in1_ctrl), .in1_wr(in1_wr), .in1_rdy(in1_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .grant(grant), .pkt_active(pkt_active), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    typedef struct {
        int n0; int n1; int len; int mode;
        int exp_words; int exp_c0; int exp_c1; int exp_n; int exp_ord[4];
    } scen_t;

    int          checks = 0;
    int          errors = 0;
    logic [71:0] exp_q0[$];
    logic [71:0] exp_q1[$];
    int          order_q[$];
    int          words_seen;
    bit          in_pkt, gap_chk, prev_active, saw_full;
    logic        prev_grant;
    int          hdr_due;
    int          rdy_mode;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int q_size(input logic p);
        return p ? exp_q1.size() : exp_q0.size();
    endfunction

    function automatic logic [71:0] q_pop(input logic p);
        if (p) return exp_q1.pop_front();
        return exp_q0.pop_front();
    endfunction

    task automatic monitor_loop();
        logic [71:0] w;
        logic        p;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_active = 1'b0;
            end else begin
                p = grant;
                w = {out_data, out_ctrl};
                if (hdr_due > 0) begin
                    hdr_due--;
                    if (hdr_due == 0) check("next_hdr_start", 72'(out_wr), 72'(1));
                end
                if (gap_chk) begin
                    check("idle_gap", 72'({pkt_active, out_wr}), 72'(0));
                    gap_chk = 1'b0;
                end
                if (pkt_active && prev_active) check("grant_stable", 72'(p), 72'(prev_grant));
                if (pkt_active && !out_wr && q_size(p) >= 2) begin
                    if (p) check("stall_head", w, exp_q1[0]);
                    else   check("stall_head", w, exp_q0[0]);
                end
                if (out_wr) begin
                    check("wr_needs_rdy", 72'(out_rdy), 72'(1));
                    if (q_size(p) == 0) check("unexpected_word", 72'(q_size(p)), 72'(1));
                    else                check("out_word", w, q_pop(p));
                    if (!in_pkt) begin
                        order_q.push_back(int'(p));
                        in_pkt = 1'b1;
                    end
                    words_seen++;
                    if (out_ctrl == 8'h08) begin
                        in_pkt  = 1'b0;
                        gap_chk = 1'b1;
                        if (rdy_mode == 0 && (exp_q0.size() + exp_q1.size()) > 0) hdr_due = 2;
                    end
                end
                prev_active = pkt_active;
                prev_grant  = p;
            end
        end
    endtask

    task automatic rdy_gen();
        forever begin
            @(posedge clk);
            #1;
            out_rdy = (rdy_mode == 1) ? !out_rdy : 1'b1;
        end
    endtask

    // Writes npkt packets of len words each, stopping after limit words in total.
    task automatic send_pkts(input int port, input int npkt, input int len, input int tag, input int limit);
        logic [71:0] w;
        int          budget;
        int          sent = 0;
        for (int p = 0; p < npkt; p++) begin
            for (int i = 0; i < len; i++) begin
                if (sent >= limit) return;
                w[71:8] = {8'(port), 8'(tag + p), 16'(i), 32'hC0DE_0000 + 32'(i)};
                w[7:0]  = (i == 0) ? 8'hFF : (i == len - 1) ? 8'h08 : 8'h00;
                budget  = 200;
                while (!(port == 1 ? in1_rdy : in0_rdy) && budget > 0) begin
                    @(posedge clk);
                    #1;
                    budget--;
                end
                if (budget == 0) begin
                    check("drv_rdy_timeout", 72'(budget), 72'(1));
                    return;
                end
                if (port == 1) begin
                    in1_data = w[71:8]; in1_ctrl = w[7:0]; in1_wr = 1'b1; exp_q1.push_back(w);
                end else begin
                    in0_data = w[71:8]; in0_ctrl = w[7:0]; in0_wr = 1'b1; exp_q0.push_back(w);
                end
                sent++;
                @(posedge clk);
                #1;
                if (port == 1) in1_wr = 1'b0;
                else           in0_wr = 1'b0;
            end
        end
    endtask

    task automatic clear_sb();
        exp_q0.delete();
        exp_q1.delete();
        order_q.delete();
        words_seen = 0;
        in_pkt     = 1'b0;
        gap_chk    = 1'b0;
        hdr_due    = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        in0_wr = 1'b0;
        in1_wr = 1'b0;
        clear_sb();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || pkt_active) && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 72'(n < 600), 72'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl[4];
        int    n;

        tbl[0] = '{1, 0, 5, 0, 5,  1, 0, 1, '{0, 0, 0, 0}};
        tbl[1] = '{2, 2, 5, 0, 20, 2, 2, 4, '{0, 1, 0, 1}};
        tbl[2] = '{0, 3, 4, 0, 12, 0, 3, 3, '{1, 1, 1, 0}};
        tbl[3] = '{1, 0, 6, 1, 6,  1, 0, 1, '{0, 0, 0, 0}};

        reset = 1'b0; out_rdy = 1'b1; rdy_mode = 0;
        in0_wr = 1'b0; in1_wr = 1'b0;
        in0_data = '0; in1_data = '0; in0_ctrl = '0; in1_ctrl = '0;
        clear_sb();
        prev_active = 1'b0; prev_grant = 1'b0; saw_full = 1'b0;
        fork
            monitor_loop();
            rdy_gen();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_wr",     72'(out_wr),     72'(0));
        check("rst_pkt_active", 72'(pkt_active), 72'(0));
        check("rst_grant",      72'(grant),      72'(0));
        check("rst_rdy",        72'({in0_rdy, in1_rdy}), 72'(2'b11));
        check("rst_cnts",       72'({pkt_cnt0, pkt_cnt1}), 72'(0));

        foreach (tbl[s]) begin
            do_reset();
            rdy_mode = tbl[s].mode;
            fork
                send_pkts(0, tbl[s].n0, tbl[s].len, 16 * s,     1000);
                send_pkts(1, tbl[s].n1, tbl[s].len, 16 * s + 8, 1000);
            join
            wait_done("scen_done");
            check("scen_words", 72'(words_seen), 72'(tbl[s].exp_words));
            check("scen_cnt0",  72'(pkt_cnt0),   72'(CNT_EN ? tbl[s].exp_c0 : 0));
            check("scen_cnt1",  72'(pkt_cnt1),   72'(CNT_EN ? tbl[s].exp_c1 : 0));
            check("scen_npkt",  72'(order_q.size()), 72'(tbl[s].exp_n));
            for (int k = 0; k < tbl[s].exp_n && k < order_q.size(); k++)
                check("scen_order", 72'(order_q[k]), 72'(tbl[s].exp_ord[k]));
        end

        // Reset in the middle of a port-0 packet, then a fresh port-1 packet.
        rdy_mode = 0;
        do_reset();
        send_pkts(0, 1, 6, 8'h50, 3);
        n = 0;
        while (words_seen < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_words", 72'(words_seen), 72'(2));
        check("mid_pre_wr", 72'(out_wr), 72'(1));
        reset = 1'b0;
        clear_sb();
        #1;
        check("mid_rst_outs", 72'({out_wr, pkt_active, grant}), 72'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rdy_after", 72'({in0_rdy, in1_rdy}), 72'(2'b11));
        send_pkts(1, 1, 4, 8'h60, 1000);
        wait_done("mid_done");
        check("mid_p1_words", 72'(words_seen), 72'(4));
        check("mid_p1_order", 72'(order_q.size() == 1 && order_q[0] == 1), 72'(1));
        check("mid_cnt1", 72'(pkt_cnt1), 72'(CNT_EN ? 1 : 0));

        // Port 1 fills up while port 0 streams a long packet.
        do_reset();
        saw_full = 1'b0;
        fork
            send_pkts(0, 1, 20, 8'h70, 1000);
            begin
                n = 0;
                while (!(pkt_active && grant == 1'b0) && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                send_pkts(1, 1, 5, 8'h78, 1000);
            end
            begin
                repeat (60) begin
                    @(negedge clk);
                    if (!in1_rdy && pkt_active && grant == 1'b0) saw_full = 1'b1;
                end
            end
        join
        wait_done("fill_done");
        check("fill_rdy_low", 72'(saw_full), 72'(1));
        check("fill_words", 72'(words_seen), 72'(25));
        check("fill_order", 72'(order_q.size() == 2 && order_q[0] == 0 && order_q[1] == 1), 72'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/secret_flow_arb.md
# secret_flow_arb

Two-port, packet-granularity round-robin arbiter that shares the single `secret_flow` crypt datapath between two upstream packet sources. Each input is buffered in a small fall-through FIFO. Whole packets are forwarded unbroken on one NetFPGA-style data/ctrl output bus, with the current grant exported so the crypt stage can select a per-port key. It sits directly upstream of `secret_flow` in the user datapath.

## Interface
- `DATA_WIDTH`, 64, data bus width.
- `CTRL_WIDTH`, `DATA_WIDTH/8`, ctrl bus width.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `in0_data` / `in1_data`  in  `DATA_WIDTH`  input words, port 0 / port 1.
- `in0_ctrl` / `in1_ctrl`  in  `CTRL_WIDTH`  input ctrl, port 0 / port 1.
- `in0_wr` / `in1_wr`  in  1  write strobes.
- `in0_rdy` / `in1_rdy`  out  1  `!nearly_full` of the matching FIFO.
- `out_data`  out  `DATA_WIDTH`  head word of the granted FIFO.
- `out_ctrl`  out  `CTRL_WIDTH`  head ctrl of the granted FIFO.
- `out_wr`  out  1  word transferred this cycle.
- `out_rdy`  in  1  downstream can accept a word.
- `grant`  out  1  port currently owning the output; key select for crypt stage.
- `pkt_active`  out  1  a packet is in flight (state ≠ IDLE).
- `pkt_cnt0` / `pkt_cnt1`  out  32  packets completed per port (see Configuration).

## Operation
- Input buffering: one `fallthrough_small_fifo` per port.
  - Width `DATA_WIDTH+CTRL_WIDTH`, `MAX_DEPTH_BITS=2`.
  - FIFO reset driven by `!reset`.
- Packet framing:
  - One or more module-header words with ctrl ≠ 0.
  - Then data words with ctrl = 0.
  - Last word (EOP) has ctrl ≠ 0.
- State machine, one-hot: `IDLE`, `HDR`, `PKT`.
- `IDLE` (decision cycle, no transfer):
  - Only one FIFO non-empty: grant that port, go to `HDR`.
  - Both non-empty: grant `!last_grant`, go to `HDR`.
  - Neither non-empty: stay in `IDLE`.
- `HDR`: when granted FIFO is non-empty and `out_rdy` is high:
  - Assert `out_wr` and pop the FIFO.
  - If the head ctrl = 0, go to `PKT`.
- `PKT`: same transfer condition as `HDR`.
  - If the head ctrl ≠ 0 (EOP): go to `IDLE`, set `last_grant <= grant`, increment that port's counter.
- Transfer rules:
  - `out_data`/`out_ctrl` always show the granted FIFO head, combinationally.
  - Downstream samples them only when `out_wr` = 1.
  - `out_wr` is combinational: (state ∈ {HDR, PKT}) & `!empty[grant]` & `out_rdy`.
- `grant` is registered and changes only on `IDLE` exit.
- The non-granted FIFO keeps accepting writes until it is nearly full.

## Timing
- Reset values:
  - State `IDLE`, `grant` = 0, `last_grant` = 1 (port 0 wins the first tie).
  - `out_wr` = 0, `pkt_active` = 0, counters = 0, FIFOs empty.
  - `out_data`/`out_ctrl` show the port-0 FIFO head (don't-care).
- Latency: a word written at edge N is at the FIFO head after edge N.
  - An idle arbiter spends the cycle after edge N in `IDLE` and grants at edge N+1.
  - The first `out_wr` comes in the cycle after edge N+1.
- Inter-packet gap: exactly one `IDLE` cycle after every EOP, even if the other port is waiting.
- Throughput within a packet: one word per cycle while data is available and `out_rdy` is high.
- Stalls:
  - `out_rdy` = 0 or granted FIFO empty: `out_wr` = 0 and state holds.
  - No switching mid-packet under any condition.
- Simultaneous events: a write to the granted FIFO in the same cycle as a pop is legal; FIFO depth is unchanged.
- Reset mid-packet: asynchronous.
  - All state and FIFOs clear immediately; `out_wr` drops in the same cycle.
  - The partial packet is discarded; downstream must tolerate the truncated packet.
- Counters wrap from 2^32−1 to 0.

## Configuration
- `SECRET_FLOW_ARB_PKT_CNT_EN` defined: `pkt_cnt0`/`pkt_cnt1` are live 32-bit EOP counters as above.
- Undefined:
  - Counter registers are not built; both ports are tied to 0.
  - All other behaviour is identical.

## Test plan
- Single packet on port 0 (hdr ctrl=0xFF, 3 data words ctrl=0, EOP ctrl=0x08), `out_rdy` = 1:
  - Exactly 5 `out_wr` pulses, words in order, `grant` = 0.
  - `pkt_cnt0` = 1, `pkt_cnt1` = 0.
- Both ports loaded with 2 packets each at the same time after reset:
  - Output packet order p0, p1, p0, p1.
  - One `IDLE` cycle between packets; no word interleaving.
- Port 1 alone sends 3 packets:
  - All granted to port 1 back-to-back, with one-cycle gaps.
  - `pkt_cnt1` = 3.
- Toggle `out_rdy` 1/0 every cycle during a 6-word packet:
  - `out_wr` only in `out_rdy`=1 cycles.
  - Data unchanged while stalled; 6 words total.
- Assert `reset` = 0 for 1 cycle after word 2 of a port-0 packet:
  - `out_wr` = 0 immediately, `in0_rdy`/`in1_rdy` = 1 after release.
  - A new port-1 packet then forwards correctly from `IDLE`.
- Fill port 1 while port 0 streams a long packet:
  - `in1_rdy` deasserts at nearly-full with no word lost.
  - Port 1 is granted immediately after port 0's EOP.
